// File: rtl/vec_fetch_decode_if.sv
// Issue beat channel from the fetch/decode front end to the execute stage.
// No latency of its own; the front end holds valid and all fields until ready is seen.
// The front end is master and drives valid and fields; execute is slave and drives ready.
interface vec_fetch_decode_if;
    logic       issue_valid;
    logic       issue_ready;
    logic [2:0] issue_op;
    logic [2:0] issue_vd;
    logic [2:0] issue_vs1;
    logic [2:0] issue_vs2;
    logic       issue_beat;

    modport master (
        output issue_valid,
        output issue_op,
        output issue_vd,
        output issue_vs1,
        output issue_vs2,
        output issue_beat,
        input  issue_ready
    );

    modport slave (
        input  issue_valid,
        input  issue_op,
        input  issue_vd,
        input  issue_vs1,
        input  issue_vs2,
        input  issue_beat,
        output issue_ready
    );
endinterface

// File: rtl/vec_fetch_decode.sv
// Vector program store plus fetch/decode/issue sequencer for OP-V arithmetic; VFD_ILLEGAL_TRAP_EN makes illegal words trap.
// Latency: start -> FETCH, DECODE, then first beat; 4 cycles per instruction with ready held high.
// Backpressure: issue_ready low holds ISSUE with valid and all fields frozen for as long as it stays low.
module vec_fetch_decode #(
    parameter int NUM_INST = 6,
    parameter int VLEN     = 32,
    parameter int VLANES   = 16,
    parameter int NREG     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      prog_we_i,
    input  logic [2:0]                prog_addr_i,
    input  logic [31:0]               prog_data_i,
    input  logic                      start_i,
    vec_fetch_decode_if.master        issue_if,
    output logic [2:0]                F_D_cycle_o,
    output logic [2:0]                pc_o,
    output logic                      done_o,
    output logic                      illegal_o
);

    localparam int         BEATS     = VLEN / VLANES;
    localparam logic       LAST_BEAT = 1'(BEATS - 1);
    localparam logic [6:0] OPC_OPV   = 7'b1010111;
    localparam logic [2:0] LAST_PC   = 3'(NUM_INST);
    localparam logic [4:0] MAX_REG   = 5'(NREG);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_ISSUE  = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    state_t      state_q;
    logic [2:0]  pc_q;
    logic        beat_q;
    logic [31:0] ir_q;
    logic        valid_q;
    logic [2:0]  op_q;
    logic [2:0]  vd_q;
    logic [2:0]  vs1_q;
    logic [2:0]  vs2_q;
    logic        done_q;
    logic        illegal_q;
    logic [31:0] mem_q [1:NUM_INST];

    logic [2:0]  dec_op;
    logic        dec_legal;
    logic        dec_zero;
    logic        prog_open;
    logic        unused_vm;

    assign unused_vm = ir_q[25];

    // A zero op code stands for "no legal funct3/funct6 match".
    always_comb begin
        dec_op = 3'd0;
        if (ir_q[6:0] == OPC_OPV) begin
            case (ir_q[14:12])
                3'b000: begin
                    case (ir_q[31:26])
                        6'b000000: dec_op = 3'd1;
                        6'b000010: dec_op = 3'd2;
                        6'b001001: dec_op = 3'd3;
                        6'b001010: dec_op = 3'd4;
                        default:   dec_op = 3'd0;
                    endcase
                end
                3'b010: begin
                    if (ir_q[31:26] == 6'b100101) begin
                        dec_op = 3'd5;
                    end
                end
                default: dec_op = 3'd0;
            endcase
        end
    end

    always_comb begin
        dec_zero  = (ir_q == 32'h0);
        dec_legal = (dec_op != 3'd0)
                  && (ir_q[11:7]  != 5'd0) && (ir_q[11:7]  <= MAX_REG)
                  && (ir_q[19:15] != 5'd0) && (ir_q[19:15] <= MAX_REG)
                  && (ir_q[24:20] != 5'd0) && (ir_q[24:20] <= MAX_REG);
    end

    assign prog_open = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i <= NUM_INST; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else if (prog_we_i && prog_open
                     && (prog_addr_i != 3'd0) && (prog_addr_i <= LAST_PC)) begin
            mem_q[prog_addr_i] <= prog_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= 3'd1;
            beat_q    <= 1'b0;
            ir_q      <= 32'h0;
            valid_q   <= 1'b0;
            op_q      <= 3'd0;
            vd_q      <= 3'd0;
            vs1_q     <= 3'd0;
            vs2_q     <= 3'd0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_FETCH;
                        pc_q    <= 3'd1;
                    end
                end
                S_FETCH: begin
                    ir_q    <= mem_q[pc_q];
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    if (dec_zero) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else if (!dec_legal) begin
                        illegal_q <= 1'b1;
`ifdef VFD_ILLEGAL_TRAP_EN
                        state_q <= S_ERROR;
`else
                        if (pc_q == LAST_PC) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            pc_q    <= pc_q + 3'd1;
                            state_q <= S_FETCH;
                        end
`endif
                    end else begin
                        op_q    <= dec_op;
                        vd_q    <= ir_q[9:7];
                        vs1_q   <= ir_q[17:15];
                        vs2_q   <= ir_q[22:20];
                        beat_q  <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (issue_if.issue_ready) begin
                        if (beat_q != LAST_BEAT) begin
                            beat_q <= beat_q + 1'b1;
                        end else begin
                            valid_q <= 1'b0;
                            // pc saturates at the last slot: a full program ends in DONE.
                            if (pc_q == LAST_PC) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                pc_q    <= pc_q + 3'd1;
                                state_q <= S_FETCH;
                            end
                        end
                    end
                end
                S_DONE, S_ERROR: begin
                    if (start_i) begin
                        state_q <= S_FETCH;
                        pc_q    <= 3'd1;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign issue_if.issue_valid = valid_q;
    assign issue_if.issue_op    = op_q;
    assign issue_if.issue_vd    = vd_q;
    assign issue_if.issue_vs1   = vs1_q;
    assign issue_if.issue_vs2   = vs2_q;
    assign issue_if.issue_beat  = beat_q;
    assign F_D_cycle_o          = state_q;
    assign pc_o                 = pc_q;
    assign done_o               = done_q;
    assign illegal_o            = illegal_q;

endmodule

// File: tb/tb_vec_fetch_decode.sv
// Bench for vec_fetch_decode: scoreboard of expected issue beats plus per-scenario timing checks.
module tb_vec_fetch_decode;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prog_we = 1'b0;
    logic [2:0]  prog_addr = 3'd0;
    logic [31:0] prog_data = 32'h0;
    logic        start = 1'b0;
    logic [2:0]  fdc;
    logic [2:0]  pc;
    logic        done;
    logic        illegal;

    always #5 clk = ~clk;

    vec_fetch_decode_if ifc ();

    vec_fetch_decode dut (
        .clk         (clk),
        .rst         (rst),
        .prog_we_i   (prog_we),
        .prog_addr_i (prog_addr),
        .prog_data_i (prog_data),
        .start_i     (start),
        .issue_if    (ifc),
        .F_D_cycle_o (fdc),
        .pc_o        (pc),
        .done_o      (done),
        .illegal_o   (illegal)
    );

    typedef struct packed {
        logic [2:0] op;
        logic [2:0] vd;
        logic [2:0] vs1;
        logic [2:0] vs2;
        logic       beat;
    } beat_t;

    beat_t sb[$];
    beat_t mon_exp;
    beat_t mon_got;
    int    total = 0;
    int    bad   = 0;

    function automatic logic [31:0] enc(input logic [5:0] f6, input logic [2:0] f3,
                                        input logic [4:0] vd, input logic [4:0] vs1,
                                        input logic [4:0] vs2);
        return {f6, 1'b1, vs2, vs1, f3, vd, 7'b1010111};
    endfunction

    task automatic push_inst(input logic [2:0] op, input logic [2:0] vd,
                             input logic [2:0] vs1, input logic [2:0] vs2);
        sb.push_back(beat_t'({op, vd, vs1, vs2, 1'b0}));
        sb.push_back(beat_t'({op, vd, vs1, vs2, 1'b1}));
    endtask

    // A handshake seen at the falling edge completes on the following rising edge.
    always @(negedge clk) begin
        if (!rst && ifc.issue_valid && ifc.issue_ready) begin
            mon_got = {ifc.issue_op, ifc.issue_vd, ifc.issue_vs1, ifc.issue_vs2, ifc.issue_beat};
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_beat got=%h required=none", mon_got);
            end else begin
                mon_exp = sb.pop_front();
                if (mon_got !== mon_exp) begin
                    bad++;
                    $display("FAIL issue_beat got=%h required=%h", mon_got, mon_exp);
                end
            end
        end
    end

    task automatic do_reset;
        rst = 1'b1;
        prog_we = 1'b0;
        start = 1'b0;
        ifc.issue_ready = 1'b0;
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic load(input logic [2:0] a, input logic [31:0] d);
        prog_we = 1'b1;
        prog_addr = a;
        prog_data = d;
        @(posedge clk);
        #1 prog_we = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // n = number of edges after the start edge at which done is first seen high, -1 on timeout.
    task automatic wait_done(input int bound, output int n);
        n = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_valid(input int bound, output bit found);
        found = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (ifc.issue_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_sb_empty(input string name);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s pending_beats=%0d required=0", name, sb.size());
        end
    endtask

    task automatic test_reset;
        do_reset();
        @(negedge clk);
        total++;
        if ({fdc, pc} !== {3'd0, 3'd1}) begin
            bad++;
            $display("FAIL reset_state got fdc=%0d pc=%0d required fdc=0 pc=1", fdc, pc);
        end
        total++;
        if ({ifc.issue_valid, done, illegal} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags got valid=%b done=%b illegal=%b required 000",
                     ifc.issue_valid, done, illegal);
        end
        total++;
        if ({ifc.issue_op, ifc.issue_vd, ifc.issue_vs1, ifc.issue_vs2, ifc.issue_beat} !== 13'h0) begin
            bad++;
            $display("FAIL reset_fields got op=%0d vd=%0d beat=%0d required zero",
                     ifc.issue_op, ifc.issue_vd, ifc.issue_beat);
        end
    endtask

    task automatic test_single;
        logic [2:0] exp_fdc [0:6];
        exp_fdc = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd1, 3'd2, 3'd4};
        do_reset();
        ifc.issue_ready = 1'b1;
        load(3'd1, 32'h021101D7);
        push_inst(3'd1, 3'd3, 3'd2, 3'd1);
        pulse_start();
        for (int n = 0; n < 7; n++) begin
            @(negedge clk);
            total++;
            if (fdc !== exp_fdc[n] || done !== (n == 6)) begin
                bad++;
                $display("FAIL single_phase n=%0d got fdc=%0d done=%b required fdc=%0d done=%b",
                         n, fdc, done, exp_fdc[n], (n == 6));
            end
        end
        check_sb_empty("single_beats");
    endtask

    task automatic test_six;
        logic [5:0] f6 [0:5];
        logic [2:0] f3 [0:5];
        logic [2:0] op [0:5];
        int n;
        f6 = '{6'b000000, 6'b000010, 6'b001001, 6'b001010, 6'b100101, 6'b000000};
        f3 = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000};
        op = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1};
        do_reset();
        ifc.issue_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            load(3'(i + 1), enc(f6[i], f3[i], 5'(i % 4 + 1), 5'((i + 1) % 4 + 1), 5'((i + 2) % 4 + 1)));
            push_inst(op[i], 3'(i % 4 + 1), 3'((i + 1) % 4 + 1), 3'((i + 2) % 4 + 1));
        end
        pulse_start();
        wait_done(60, n);
        total++;
        if (n != 24 || pc !== 3'd6) begin
            bad++;
            $display("FAIL six_done got edges=%0d pc=%0d required edges=24 pc=6", n, pc);
        end
        check_sb_empty("six_beats");
    endtask

    task automatic test_stall;
        bit found;
        int n;
        do_reset();
        load(3'd1, enc(6'b000010, 3'b000, 5'd4, 5'd3, 5'd2));
        push_inst(3'd2, 3'd4, 3'd3, 3'd2);
        pulse_start();
        wait_valid(10, found);
        total++;
        if (!found) begin
            bad++;
            $display("FAIL stall_valid got valid=0 required valid=1");
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({ifc.issue_valid, ifc.issue_op, ifc.issue_vd, ifc.issue_vs1, ifc.issue_vs2, ifc.issue_beat}
                !== {1'b1, 3'd2, 3'd4, 3'd3, 3'd2, 1'b0}) begin
                bad++;
                $display("FAIL stall_hold cyc=%0d got valid=%b op=%0d vd=%0d beat=%0d required 1/2/4/0",
                         i, ifc.issue_valid, ifc.issue_op, ifc.issue_vd, ifc.issue_beat);
            end
        end
        @(posedge clk);
        #1 ifc.issue_ready = 1'b1;
        wait_done(20, n);
        total++;
        if (n < 0) begin
            bad++;
            $display("FAIL stall_done got timeout required done");
        end
        check_sb_empty("stall_beats");
    endtask

    task automatic test_illegal;
        int pulses;
        do_reset();
        ifc.issue_ready = 1'b1;
        load(3'd1, enc(6'b001001, 3'b000, 5'd1, 5'd2, 5'd3));
        load(3'd2, enc(6'b000000, 3'b000, 5'd7, 5'd1, 5'd2));
        load(3'd3, enc(6'b100101, 3'b010, 5'd2, 5'd3, 5'd4));
        push_inst(3'd3, 3'd1, 3'd2, 3'd3);
`ifndef VFD_ILLEGAL_TRAP_EN
        push_inst(3'd5, 3'd2, 3'd3, 3'd4);
`endif
        pulses = 0;
        pulse_start();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (illegal === 1'b1) begin
                pulses++;
                total++;
`ifdef VFD_ILLEGAL_TRAP_EN
                if ({fdc, pc} !== {3'd5, 3'd2}) begin
                    bad++;
                    $display("FAIL illegal_next got fdc=%0d pc=%0d required fdc=5 pc=2", fdc, pc);
                end
`else
                if ({fdc, pc} !== {3'd1, 3'd3}) begin
                    bad++;
                    $display("FAIL illegal_next got fdc=%0d pc=%0d required fdc=1 pc=3", fdc, pc);
                end
`endif
            end
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL illegal_pulses got=%0d required=1", pulses);
        end
        total++;
`ifdef VFD_ILLEGAL_TRAP_EN
        if ({fdc, pc, done} !== {3'd5, 3'd2, 1'b0}) begin
            bad++;
            $display("FAIL illegal_end got fdc=%0d pc=%0d done=%b required 5/2/0", fdc, pc, done);
        end
`else
        if ({fdc, pc, done} !== {3'd4, 3'd4, 1'b1}) begin
            bad++;
            $display("FAIL illegal_end got fdc=%0d pc=%0d done=%b required 4/4/1", fdc, pc, done);
        end
`endif
        check_sb_empty("illegal_beats");
    endtask

    task automatic test_rst_mid_issue;
        bit found;
        int n;
        do_reset();
        load(3'd1, 32'h021101D7);
        pulse_start();
        wait_valid(10, found);
        total++;
        if (!found) begin
            bad++;
            $display("FAIL rst_issue_valid got valid=0 required valid=1");
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        ifc.issue_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ifc.issue_ready = 1'b0;
        @(negedge clk);
        total++;
        if ({fdc, ifc.issue_valid, pc, done} !== {3'd0, 1'b0, 3'd1, 1'b0}) begin
            bad++;
            $display("FAIL rst_issue_state got fdc=%0d valid=%b pc=%0d done=%b required 0/0/1/0",
                     fdc, ifc.issue_valid, pc, done);
        end
        ifc.issue_ready = 1'b1;
        pulse_start();
        wait_done(10, n);
        total++;
        if (n != 2) begin
            bad++;
            $display("FAIL rst_mem_cleared got edges=%0d required edges=2", n);
        end
        check_sb_empty("rst_beats");
    endtask

    task automatic test_prog_we;
        bit found;
        int n;
        logic [31:0] wa;
        logic [31:0] wb;
        logic [31:0] wc;
        wa = enc(6'b001010, 3'b000, 5'd2, 5'd4, 5'd1);
        wb = enc(6'b000010, 3'b000, 5'd3, 5'd3, 5'd3);
        wc = enc(6'b100101, 3'b010, 5'd1, 5'd1, 5'd4);
        do_reset();
        load(3'd1, wa);
        push_inst(3'd4, 3'd2, 3'd4, 3'd1);
        pulse_start();
        wait_valid(10, found);
        @(posedge clk);
        #1 load(3'd1, wb);
        ifc.issue_ready = 1'b1;
        wait_done(20, n);
        total++;
        if (!found || n < 0) begin
            bad++;
            $display("FAIL we_issue_run1 got found=%b edges=%0d required completion", found, n);
        end
        push_inst(3'd4, 3'd2, 3'd4, 3'd1);
        pulse_start();
        wait_done(20, n);
        total++;
        if (n != 6) begin
            bad++;
            $display("FAIL we_issue_run2 got edges=%0d required edges=6", n);
        end
        check_sb_empty("we_issue_beats");
        push_inst(3'd5, 3'd1, 3'd1, 3'd4);
        prog_we = 1'b1;
        prog_addr = 3'd1;
        prog_data = wc;
        start = 1'b1;
        @(posedge clk);
        #1;
        prog_we = 1'b0;
        start = 1'b0;
        wait_done(20, n);
        total++;
        if (n != 6) begin
            bad++;
            $display("FAIL we_start_same got edges=%0d required edges=6", n);
        end
        check_sb_empty("we_start_beats");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1);
    end

    initial begin
        ifc.issue_ready = 1'b0;
        test_reset();
        test_single();
        test_six();
        test_stall();
        test_illegal();
        test_rst_mid_issue();
        test_prog_we();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
